// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: the frame-sequencing state type,
// the frame constants and the parity helper used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_START_BIT   = 1'b0;
    localparam logic UART_STOP_BIT    = 1'b1;
    localparam logic UART_PARITY_EVEN = 1'b0;
    localparam logic UART_PARITY_ODD  = 1'b1;

    // Parity bit that makes (data bits XOR parity bit) equal the selected mode.
    function automatic logic uart_calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                              input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to
// RESET_VAL so the synchronised output starts at the line's idle level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: sends start, 8 data bits LSB first, optional parity and
// one stop bit on out, CLKS_PER_BIT clocks per bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [UART_DATA_BITS-1:0] data_in,
    output logic                      out,
    output logic                      busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             PAR_ODD_L = (PARITY_ODD != 0);

    uart_rx_state_t            r_state;
    uart_rx_state_t            w_next_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_next_idx;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_out;
    logic                      r_busy;
    logic                      w_bit_end;

    assign w_bit_end = (r_cnt == BIT_LAST);

    // Next state and next data-bit index.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = 3'd0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_START;
                else       w_next_state = ST_IDLE;
            end
            ST_START: begin
                if (w_bit_end) w_next_state = ST_DATA;
                else           w_next_state = ST_START;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_next_idx = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end else begin
                    w_next_idx   = r_bit_idx;
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_next_state = ST_STOP;
                else           w_next_state = ST_PARITY;
            end
            ST_STOP: begin
                if (w_bit_end) w_next_state = ST_IDLE;
                else           w_next_state = ST_STOP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Bit timing, payload latch and registered line level for the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_data    <= '0;
            r_out     <= UART_STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            r_busy    <= (w_next_state != ST_IDLE);
            r_bit_idx <= w_next_idx;
            if (r_state == ST_IDLE || w_bit_end) r_cnt <= '0;
            else                                 r_cnt <= r_cnt + CNT_ONE;
            if (r_state == ST_IDLE && start) r_data <= data_in;
            else                             r_data <= r_data;
            case (w_next_state)
                ST_IDLE:   r_out <= UART_STOP_BIT;
                ST_START:  r_out <= UART_START_BIT;
                ST_DATA:   r_out <= r_data[w_next_idx];
                ST_PARITY: r_out <= uart_calc_parity(r_data, PAR_ODD_L);
                ST_STOP:   r_out <= UART_STOP_BIT;
                default:   r_out <= UART_STOP_BIT;
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, times each bit from the start edge, checks
// start/parity/stop and strobes the recovered byte with an error flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      done_r,
    output logic                      error,
    output logic                      busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             PAR_ODD_L = (PARITY_ODD != 0);

    uart_rx_state_t            r_state;
    uart_rx_state_t            w_next_state;
    logic                      w_rx_s;
    logic                      w_fall;
    logic                      w_tick;
    logic                      r_rx_prev;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_par_err;
    logic [UART_DATA_BITS-1:0] r_data_out;
    logic                      r_done;
    logic                      r_error;
    logic                      r_busy;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // Requiring a 1->0 transition keeps a line stuck low from retriggering.
    assign w_fall = r_rx_prev & ~w_rx_s;

    // Next state and the mid-bit sample tick of the current state.
    always_comb begin
        w_next_state = r_state;
        w_tick       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_next_state = ST_START;
                else        w_next_state = ST_IDLE;
            end
            ST_START: begin
                w_tick = (r_cnt == HALF_LAST);
                if (w_tick) begin
                    if (w_rx_s == UART_START_BIT) w_next_state = ST_DATA;
                    else                          w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_DATA: begin
                w_tick = (r_cnt == FULL_LAST);
                if (w_tick && r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
                    w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                w_tick = (r_cnt == FULL_LAST);
                if (w_tick) w_next_state = ST_STOP;
                else        w_next_state = ST_PARITY;
            end
            ST_STOP: begin
                w_tick = (r_cnt == FULL_LAST);
                if (w_tick) w_next_state = ST_IDLE;
                else        w_next_state = ST_STOP;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_tick       = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Counters, shift register, parity/stop checks and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_prev  <= 1'b1;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_busy    <= (w_next_state != ST_IDLE);
            r_done    <= 1'b0;
            r_error   <= 1'b0;

            if (r_state == ST_IDLE || w_tick) r_cnt <= '0;
            else                              r_cnt <= r_cnt + CNT_ONE;

            if (r_state != ST_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_tick) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end

            if (r_state == ST_START) begin
                r_par_err <= 1'b0;
            end else if (r_state == ST_PARITY && w_tick) begin
                r_par_err <= (w_rx_s != uart_calc_parity(r_shift, PAR_ODD_L));
            end else begin
                r_par_err <= r_par_err;
            end

            // The byte is published even when the frame is flagged bad.
            if (r_state == ST_STOP && w_tick) begin
                r_data_out <= r_shift;
                r_done     <= 1'b1;
                r_error    <= r_par_err | (w_rx_s != UART_STOP_BIT);
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

    assign data_out = r_data_out;
    assign done_r   = r_done;
    assign error    = r_error;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a plain-parity instance, a parity instance and a
// transmitter loopback, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rx0_drv = 1'b1;
    logic       rx1     = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_out, tx_busy;
    logic       rx0;
    logic [7:0] data0, data1;
    logic       done0, done1, err0, err1, busy0, busy1;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_cyc0 = 0;
    int stray_err = 0;
    logic [8:0] hist0[$];
    logic [8:0] hist1[$];

    assign rx0 = loop_en ? tx_out : rx0_drv;

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(data0),
        .done_r(done0), .error(err0), .busy(busy0));

    uart_receiver #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(data1),
        .done_r(done1), .error(err1), .busy(busy1));

    uart_transmitter #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_tx (
        .clk(clk), .rst(rst), .start(tx_start), .data_in(tx_data),
        .out(tx_out), .busy(tx_busy));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done0) begin
            hist0.push_back({err0, data0});
            last_cyc0 <= cyc;
        end
        if (done1) hist1.push_back({err1, data1});
        if ((err0 && !done0) || (err1 && !done1)) stray_err <= stray_err + 1;
    end

    // Expected {error, byte} of one frame on the even-parity line.
    function automatic logic [8:0] ref_frame(input logic [7:0] d, input bit par_en,
                                             input logic pbit, input logic stopv);
        logic e;
        e = (stopv == 1'b0) || (par_en && (pbit != (^d)));
        return {e, d};
    endfunction

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx0_drv = v;
        else          rx1     = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                              input logic pbit, input logic stopv, output int s);
        set_rx(sel, 1'b0);
        s = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            repeat (CPB) @(negedge clk);
        end
        if (par_en) begin
            set_rx(sel, pbit);
            repeat (CPB) @(negedge clk);
        end
        set_rx(sel, stopv);
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({data0, done0, err0, busy0} !== 11'd0) begin
            errors++;
            $display("FAIL reset_dut0 got %h/%b%b%b want 00/000", data0, done0, err0, busy0);
        end
        checks++;
        if ({data1, done1, err1, busy1} !== 11'd0) begin
            errors++;
            $display("FAIL reset_dut1 got %h/%b%b%b want 00/000", data1, done1, err1, busy1);
        end
        rst = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (hist0.size() + hist1.size() != 0) begin
            errors++;
            $display("FAIL reset_release_strobe got %0d want 0", hist0.size() + hist1.size());
        end
    endtask

    task automatic test_nominal;
        int n, s, dt;
        n = hist0.size();
        send_frame(0, 8'hDC, 1'b0, 1'b0, 1'b1, s);
        repeat (20) @(negedge clk);
        checks++;
        if (hist0.size() != n + 1) begin
            errors++;
            $display("FAIL nominal_count got %0d want %0d", hist0.size(), n + 1);
        end else begin
            checks++;
            if (hist0[n] !== 9'h0DC) begin
                errors++;
                $display("FAIL nominal_data got %h want 0dc", hist0[n]);
            end
            dt = last_cyc0 - s;
            checks++;
            if (dt < 155 || dt > 156) begin
                errors++;
                $display("FAIL nominal_latency got %0d want 155..156", dt);
            end
        end
    endtask

    task automatic test_glitch;
        int n;
        n = hist0.size();
        rx0_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx0_drv = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high got %b want 1", busy0);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_low got %b want 0", busy0);
        end
        repeat (200) @(negedge clk);
        checks++;
        if (hist0.size() != n) begin
            errors++;
            $display("FAIL glitch_strobe got %0d want %0d", hist0.size(), n);
        end
    endtask

    task automatic test_framing;
        int n, s;
        n = hist0.size();
        send_frame(0, 8'h3A, 1'b0, 1'b0, 1'b0, s);
        repeat (200) @(negedge clk);
        checks++;
        if (hist0.size() != n + 1) begin
            errors++;
            $display("FAIL break_count got %0d want %0d", hist0.size(), n + 1);
        end else begin
            checks++;
            if (hist0[n] !== 9'h13A) begin
                errors++;
                $display("FAIL break_frame got %h want 13a", hist0[n]);
            end
        end
        rx0_drv = 1'b1;
        repeat (20) @(negedge clk);
        n = hist0.size();
        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1, s);
        repeat (20) @(negedge clk);
        checks++;
        if (hist0.size() != n + 1 || hist0[n] !== 9'h001) begin
            errors++;
            $display("FAIL after_break got n=%0d last=%h want n=%0d 001",
                     hist0.size(), hist0[hist0.size()-1], n + 1);
        end
    endtask

    task automatic test_parity;
        int n, s;
        logic [8:0] exp;
        for (int k = 0; k < 2; k++) begin
            n = hist1.size();
            exp = ref_frame(8'hDC, 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b1);
            send_frame(1, 8'hDC, 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b1, s);
            repeat (20) @(negedge clk);
            checks++;
            if (hist1.size() != n + 1 || hist1[n] !== exp) begin
                errors++;
                $display("FAIL parity_fixed%0d got n=%0d last=%h want %h",
                         k, hist1.size(), hist1[hist1.size()-1], exp);
            end
        end
    endtask

    task automatic test_random;
        int n, s;
        logic [7:0] d;
        logic pbit, stopv;
        logic [8:0] exp;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            n = hist0.size();
            send_frame(0, d, 1'b0, 1'b0, 1'b1, s);
            repeat (20) @(negedge clk);
            checks++;
            if (hist0.size() != n + 1 || hist0[n] !== ref_frame(d, 1'b0, 1'b0, 1'b1)) begin
                errors++;
                $display("FAIL rand0_%0d got n=%0d last=%h want %h", k, hist0.size(),
                         hist0[hist0.size()-1], ref_frame(d, 1'b0, 1'b0, 1'b1));
            end
        end
        for (int k = 0; k < 8; k++) begin
            d     = 8'($urandom_range(0, 255));
            pbit  = 1'($urandom_range(0, 1));
            stopv = ($urandom_range(0, 3) != 0);
            exp   = ref_frame(d, 1'b1, pbit, stopv);
            n = hist1.size();
            send_frame(1, d, 1'b1, pbit, stopv, s);
            rx1 = 1'b1;
            repeat (20) @(negedge clk);
            checks++;
            if (hist1.size() != n + 1 || hist1[n] !== exp) begin
                errors++;
                $display("FAIL rand1_%0d got n=%0d last=%h want %h", k, hist1.size(),
                         hist1[hist1.size()-1], exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n, s;
        n = hist0.size();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, s);
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b1, s);
        repeat (20) @(negedge clk);
        checks++;
        if (hist0.size() != n + 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", hist0.size(), n + 2);
        end else begin
            checks++;
            if (hist0[n] !== 9'h055 || hist0[n+1] !== 9'h0A3) begin
                errors++;
                $display("FAIL b2b_order got %h,%h want 055,0a3", hist0[n], hist0[n+1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        n = hist0.size();
        rx0_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx0_drv = 1'(i % 2);
            repeat (CPB) @(negedge clk);
        end
        rx0_drv = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before got %b want 1", busy0);
        end
        rst = 1'b0;
        rx0_drv = 1'b1;
        @(negedge clk);
        checks++;
        if ({data0, done0, err0, busy0} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h/%b%b%b want 00/000", data0, done0, err0, busy0);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (hist0.size() != n) begin
            errors++;
            $display("FAIL midreset_strobe got %0d want %0d", hist0.size(), n);
        end
    endtask

    task automatic test_loopback;
        int n;
        n = hist0.size();
        loop_en  = 1'b1;
        tx_data  = 8'hDC;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        checks++;
        if (hist0.size() != n + 1 || hist0[n] !== 9'h0DC) begin
            errors++;
            $display("FAIL loopback got n=%0d last=%h want n=%0d 0dc",
                     hist0.size(), hist0[hist0.size()-1], n + 1);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_nominal;
        test_glitch;
        test_framing;
        test_parity;
        test_random;
        test_back_to_back;
        test_reset_mid_frame;
        test_loopback;
        checks++;
        if (stray_err != 0) begin
            errors++;
            $display("FAIL error_without_done got %0d want 0", stray_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
